// File: rtl/muldiv_pkg.sv
// Shared types and funct3 encodings for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    // funct3 bit that separates divides from multiplies
    localparam int IS_DIV_BIT = 2;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One combinational restoring-division iteration: trial-subtract the divisor
// from the shifted partial remainder and keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: magnitude-based shift-add / restoring divide
// with final sign fix-up. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
//
// state | meaning
// IDLE  | waiting for start; latches magnitudes, signs and funct3
// CALC  | one multiply or divide step per cycle, WIDTH steps
// DONE  | sign-corrected result presented, done pulses for one cycle
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          fn_q, fn_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic                special_q, special_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    result_q, result_d;

    logic                a_signed, b_signed, a_neg_in, b_neg_in;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_acc, div_acc, prod;
    logic [WIDTH:0]      div_rem_in;
    logic [WIDTH-1:0]    div_rem_out;
    logic                div_q_bit;
    logic [WIDTH-1:0]    fixed;
    logic                show_done;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (div_rem_in),
        .divisor (b_q),
        .rem_out (div_rem_out),
        .q_bit   (div_q_bit)
    );

    // Accumulator layout is {hi, lo}: product halves, or {remainder, quotient}.
    assign div_rem_in = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_acc    = {div_rem_out, acc_q[WIDTH-2:0], div_q_bit};
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        a_signed = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
        b_signed = a_signed && (funct3 != F_MULHSU);
        a_neg_in = a_signed && op_a[WIDTH-1];
        b_neg_in = b_signed && op_b[WIDTH-1];
        a_mag    = a_neg_in ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg_in ? (~op_b + 1'b1) : op_b;
    end

    always_comb begin
        prod  = (a_neg_q ^ b_neg_q) ? (~acc_q + 1'b1) : acc_q;
        fixed = '0;
        if (special_q) begin
            fixed = acc_q[WIDTH-1:0];
        end else if (!fn_q[IS_DIV_BIT]) begin
            fixed = (fn_q == F_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end else if (fn_q == F_REM || fn_q == F_REMU) begin
            fixed = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fixed = (a_neg_q ^ b_neg_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fn_d      = fn_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        special_d = special_q;
        acc_d     = acc_q;
        b_d       = b_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fn_d      = funct3;
                    a_neg_d   = a_neg_in;
                    b_neg_d   = b_neg_in;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d       = b_mag;
                    special_d = 1'b0;
                    state_d   = CALC;
                    if (funct3[IS_DIV_BIT]) begin
                        if (op_b == '0) begin
                            special_d            = 1'b1;
                            acc_d[WIDTH-1:0]     = funct3[1] ? op_a : '1;
                            state_d              = DONE;
                        end else if (!funct3[0] && op_b == '1 &&
                                     op_a == {1'b1, {(WIDTH-1){1'b0}}}) begin
                            special_d            = 1'b1;
                            acc_d[WIDTH-1:0]     = funct3[1] ? '0 : op_a;
                            state_d              = DONE;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        state_d = DONE;
`endif
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = fn_q[IS_DIV_BIT] ? div_acc : mul_acc;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = fixed;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fn_q      <= F_MUL;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            b_q       <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fn_q      <= fn_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            special_q <= special_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            result_q  <= result_d;
        end
    end

    // The result is visible during DONE itself, then held in result_q.
    assign show_done = (state_q == DONE) && !flush && !rst;
    assign done      = show_done;
    assign result    = show_done ? fixed : result_q;
    assign stall     = !rst && (((state_q == IDLE) && start) || (state_q == CALC));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH 32); mul latency
// expectation follows MULDIV_FAST_MUL_EN.
module tb_muldiv_sequencer;

    localparam int LAT_ITER = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int tests_run;
    int tests_failed;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int  cyc;
        int  stall_cnt;
        bit  got;
        cyc = 0;
        stall_cnt = 0;
        got = 0;
        funct3 = fn;
        op_a = a;
        op_b = b;
        while (!got && cyc <= lat + 5) begin
            start = (cyc == 0);
            #1;
            if (stall) stall_cnt++;
            if (done) begin
                got = 1;
                tests_run++;
                if (result !== exp) begin
                    tests_failed++;
                    $display("FAIL %s result: got %h expected %h", nm, result, exp);
                end
                tests_run++;
                if (cyc !== lat) begin
                    tests_failed++;
                    $display("FAIL %s latency: got %0d expected %0d", nm, cyc, lat);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen within %0d cycles", nm, lat + 6);
        end
        tests_run++;
        if (stall_cnt !== lat) begin
            tests_failed++;
            $display("FAIL %s stall cycles: got %0d expected %0d", nm, stall_cnt, lat);
        end
        #1;
        tests_run++;
        if (done !== 1'b0 || result !== exp) begin
            tests_failed++;
            $display("FAIL %s hold: done %b result %h expected done 0 result %h", nm, done, result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        funct3 = 3'b100;
        op_a = 32'd100;
        op_b = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: stall %b done %b result %h expected 0 0 00000000", stall, done, result);
        end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_idle: stall %b done %b result %h expected 0 0 00000000", stall, done, result);
        end
    endtask

    task automatic test_div();
        run_op(3'b100, 32'd100,        32'd7, 32'd14,         LAT_ITER, "div_100_7");
        run_op(3'b110, 32'd100,        32'd7, 32'd2,          LAT_ITER, "rem_100_7");
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD,  LAT_ITER, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF,  LAT_ITER, "rem_m7_2");
        run_op(3'b101, 32'hFFFF_FFF9,  32'd2, 32'h7FFF_FFFC,  LAT_ITER, "divu_big_2");
    endtask

    task automatic test_div_special();
        run_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, "div_by_zero");
        run_op(3'b111, 32'd5,          32'd0,         32'd5,         1, "remu_by_zero");
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1, "rem_overflow");
    endtask

    task automatic test_mul();
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         LAT_MUL, "mulh_m1_m1");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL, "mulhu_max");
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         LAT_MUL, "mul_m1_m1");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_MUL, "mulhsu_m1_2");
    endtask

    task automatic test_flush();
        bit seen_done;
        seen_done = 0;
        funct3 = 3'b100;
        op_a = 32'd1000;
        op_b = 32'd7;
        for (int c = 0; c < 45; c++) begin
            start = (c == 0);
            flush = (c == 10);
            #1;
            if (done) seen_done = 1;
            if (c == 10) begin
                tests_run++;
                if (stall !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL flush_cycle_stall: got %b expected 1", stall);
                end
            end
            if (c == 11) begin
                tests_run++;
                if (stall !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL flush_stall_drop: got %b expected 0", stall);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        flush = 1'b0;
        tests_run++;
        if (seen_done) begin
            tests_failed++;
            $display("FAIL flush_no_done: got done pulse expected none");
        end
        #1;
        tests_run++;
        if (result !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL flush_result_held: got %h expected ffffffff", result);
        end
        run_op(3'b101, 32'd9, 32'd3, 32'd3, LAT_ITER, "divu_after_flush");
    endtask

    task automatic test_reset_mid_calc();
        funct3 = 3'b100;
        op_a = 32'd100;
        op_b = 32'd7;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_calc: stall %b done %b result %h expected 0 0 00000000", stall, done, result);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_calc_idle: stall got %b expected 0", stall);
        end
    endtask

    task automatic test_back_to_back();
        int  pulses;
        bit  prev_done;
        int  budget;
        pulses = 0;
        prev_done = 0;
        budget = 4 * LAT_MUL + 10;
        funct3 = 3'b000;
        op_a = 32'd3;
        op_b = 32'd4;
        start = 1'b1;
        for (int c = 0; c < budget && pulses < 2; c++) begin
            #1;
            if (done) begin
                tests_run++;
                if (prev_done) begin
                    tests_failed++;
                    $display("FAIL b2b_consecutive_done: done high two cycles at cycle %0d", c);
                end
                pulses++;
                if (pulses == 1) begin
                    tests_run++;
                    if (result !== 32'd12 || c !== LAT_MUL) begin
                        tests_failed++;
                        $display("FAIL b2b_first: got %h at cycle %0d expected 0000000c at cycle %0d", result, c, LAT_MUL);
                    end
                    op_a = 32'd5;
                    op_b = 32'd6;
                end else begin
                    tests_run++;
                    if (result !== 32'd30 || c !== 2 * LAT_MUL + 1) begin
                        tests_failed++;
                        $display("FAIL b2b_second: got %h at cycle %0d expected 0000001e at cycle %0d", result, c, 2 * LAT_MUL + 1);
                    end
                end
            end
            prev_done = done;
            @(posedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (pulses !== 2) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end
        repeat (2 * LAT_MUL + 4) @(posedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        funct3 = 3'b000;
        op_a = '0;
        op_b = '0;
        test_reset();
        test_div();
        test_div_special();
        test_mul();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations, sitting beside the ALU in the execute stage. It accepts one M-extension operation from decode/execute, holds the pipeline with a stall while it iterates, and presents the result for exactly one cycle when the pipeline is released. The hazard/stall logic ORs `stall` into its front-end stall and holds the instruction in execute; a branch/jump flush aborts an in-flight operation.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  input  1  the block's single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  valid M-extension op present in execute (opcode 0110011, funct7 0000001).
- `funct3`  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  WIDTH  rs1 value (forwarded).
- `op_b`  input  WIDTH  rs2 value (forwarded).
- `flush`  input  1  abort current operation.
- `stall`  output  1  hold fetch/decode/execute.
- `done`  output  1  one-cycle pulse; `result` is valid.
- `result`  output  WIDTH  operation result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start` is sampled only here; operands are latched as magnitudes; sign flags and `funct3` are recorded; the iteration counter is set to 0.
- IDLE -> CALC on `start`, except for special divides, which go directly IDLE -> DONE.
- CALC runs one shift-add (multiply) or restoring-subtract (divide) step per cycle. It moves to DONE after step `WIDTH`-1.
- DONE applies sign correction, drives `result`, asserts `done`, then moves to IDLE. `start` is ignored in DONE; a back-to-back M-op arrives in the following IDLE cycle.
- Multiply: 2*`WIDTH` accumulator. MUL returns the low half. MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned semantics; the product is negated when the operand signs differ under the signed interpretation.
- Divide: the quotient sign is sign(a) XOR sign(b); the remainder takes the sign of the dividend.
- Special cases, resolved in one cycle:
  - divisor 0: quotient all-ones, remainder = `op_a`.
  - signed overflow (`op_a` = most negative, `op_b` = -1): quotient = `op_a`, remainder 0.
- `stall` = (IDLE && `start`) || CALC. It is 0 in DONE, so the pipeline advances on the same edge it consumes `result`.
- `flush`, in any state: next state IDLE, `done` stays 0, `result` is unchanged. `flush` has priority over `start`.
- `rst` has priority over everything.

## Timing
- Reset values: state IDLE, `result` 0, `done` 0, counter 0. `stall` is forced to 0 while `rst` is high.
- Iterative op: `start` at cycle t → `stall` high cycles t..t+`WIDTH`; DONE and `done`=1 at cycle t+`WIDTH`+1.
- Special divide: `start` at t → `done` at t+1; `stall` high only at t.
- `done` is never high for more than one consecutive cycle.
- `result` holds its value after DONE until the next DONE.
- `flush` at cycle t while in CALC → IDLE at t+1, and no `done` follows.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: multiplies compute the full product in one cycle with a native multiplier, IDLE -> DONE, latency 1, `stall` high only at the start cycle. Divides are unchanged.
- Not defined: multiplies use the `WIDTH`-cycle shift-add path described above. This is the area-minimal default.

## Structure
- `muldiv_pkg`:
  - state enum (IDLE, CALC, DONE).
  - localparams for the eight `funct3` codes.
  - helper localparam `IS_DIV_BIT` = funct3[2].
- One sub-module, `div_step`: combinational single restoring-division iteration (partial remainder, divisor → next remainder, quotient bit), instantiated once. The sequencer holds all registers.

## Test plan
- DIV 100 / 7 (`WIDTH` 32): `stall` high 33 cycles; `done` at t+33 with `result` 14. REM of the same operands → 2.
- DIV -7 / 2 → 0xFFFFFFFD (-3). REM -7 / 2 → 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIV 5 / 0 → 0xFFFFFFFF at t+1, and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same → 0, both at t+1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0. MULHU of the same → 0xFFFFFFFE. MUL of the same → 1. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF. Check the latency in both configurations.
- `flush` at cycle t+10 of a DIV: `done` never asserts, `stall` drops at t+11. A following DIVU 9 / 3 completes normally with 3.
- `rst` asserted mid-CALC: the next cycle shows `stall`=0, `done`=0, `result`=0. `start` held high through DONE on back-to-back MUL 3 × 4 then MUL 5 × 6: two distinct `done` pulses with 12 then 30.
